cmd_exec_seq: RTL and testbench

// - Instruction read/execute sequencer feeding the register/PC stage: fetches the 8-bit

---
 rtl/cmd_pkg.sv | 54 +++++
 rtl/cmd_exec_seq_if.sv | 28 ++
 rtl/cmd_alu.sv | 99 +++++++++
 rtl/cmd_exec_seq.sv | 161 ++++++++++++++++
 tb/tb_cmd_exec_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : cmd_pkg
// Desc     : Shared definitions for the instruction sequencer: opcode values,
//            FSM state encoding and instruction-word field positions.
// Revision : 1.0
// ----------------------------------------------------------------------------
package cmd_pkg;

  // Instruction word layout: [7:4] opcode, [3:2] rd, [1:0] rs
  localparam int INSTR_W   = 8;
  localparam int OPC_LSB   = 4;
  localparam int OPC_W     = 4;
  localparam int RD_LSB    = 2;
  localparam int RS_LSB    = 0;
  localparam int REG_IDX_W = 2;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'h6;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'h7;
  localparam logic [OPC_W-1:0] OP_INC  = 4'h8;
  localparam logic [OPC_W-1:0] OP_DEC  = 4'h9;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'hA;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hB;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [INSTR_W-1:0] ir);
    return ir[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_IDX_W-1:0] ir_rd(input logic [INSTR_W-1:0] ir);
    return ir[RD_LSB +: REG_IDX_W];
  endfunction

  function automatic logic [REG_IDX_W-1:0] ir_rs(input logic [INSTR_W-1:0] ir);
    return ir[RS_LSB +: REG_IDX_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_exec_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface: cmd_exec_seq_if
// Desc     : Instruction-memory read port. The sequencer (master) presents an
//            address with a one-cycle read strobe; the memory (slave) returns
//            the instruction word in the following cycle.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface cmd_exec_seq_if #(
  parameter int AW = 8
);
  logic [AW-1:0] instr_addr;
  logic          instr_rd;
  logic [7:0]    instr_data;

  modport master (
    output instr_addr,
    output instr_rd,
    input  instr_data
  );

  modport slave (
    input  instr_addr,
    input  instr_rd,
    output instr_data
  );
endinterface
`default_nettype wire

// File: rtl/cmd_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cmd_alu
// Desc     : Combinational ALU for the sequencer. Produces the truncated result,
//            the carry/borrow bit, whether the opcode updates carry, and whether
//            the opcode writes a register at all.
// Revision : 1.0
// ----------------------------------------------------------------------------
module cmd_alu
  import cmd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [DW-1:0]    result,
  output logic             carry,
  output logic             carry_upd,
  output logic             writes
);

  logic [DW:0] wide;

  // Opcode decode and arithmetic; the extra top bit of 'wide' is carry/borrow
  always_comb begin
    wide      = '0;
    result    = '0;
    carry     = 1'b0;
    carry_upd = 1'b0;
    writes    = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        result    = wide[DW-1:0];
        carry     = wide[DW];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        result    = wide[DW-1:0];
        carry     = wide[DW];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        writes = 1'b1;
      end
      OP_OR: begin
        result = a | b;
        writes = 1'b1;
      end
      OP_XOR: begin
        result = a ^ b;
        writes = 1'b1;
      end
      OP_NOT: begin
        result = ~a;
        writes = 1'b1;
      end
      OP_MOV: begin
        result = b;
        writes = 1'b1;
      end
      OP_INC: begin
        wide      = {1'b0, a} + {{DW{1'b0}}, 1'b1};
        result    = wide[DW-1:0];
        carry     = wide[DW];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_DEC: begin
        wide      = {1'b0, a} - {{DW{1'b0}}, 1'b1};
        result    = wide[DW-1:0];
        carry     = wide[DW];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_SHL: begin
        result    = {a[DW-2:0], 1'b0};
        carry     = a[DW-1];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_SHR: begin
        result    = {1'b0, a[DW-1:1]};
        carry     = a[0];
        carry_upd = 1'b1;
        writes    = 1'b1;
      end
      OP_NOP:  ;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cmd_exec_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cmd_exec_seq
// Desc     : Instruction read/execute sequencer. Fetches the instruction at PC,
//            decodes it, executes on R0..R3 and issues a write-back pulse plus a
//            PC-advance pulse. One instruction per start pulse, or free-running
//            until HALT when CMD_EXEC_AUTORUN_EN is defined.
// Revision : 1.0
// ----------------------------------------------------------------------------
module cmd_exec_seq
  import cmd_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [AW-1:0]     PC,
  input  logic [DW-1:0]     R0,
  input  logic [DW-1:0]     R1,
  input  logic [DW-1:0]     R2,
  input  logic [DW-1:0]     R3,
  cmd_exec_seq_if.master    imem,
  output logic [DW-1:0]     res_alu,
  output logic [1:0]        res_dest,
  output logic              enact,
  output logic              pc_inc,
  output logic              busy,
  output logic              halted,
  output logic              flag_c,
  output logic              flag_z
);

  state_t               state;
  state_t               state_nxt;
  logic [INSTR_W-1:0]   ir;
  logic [OPC_W-1:0]     opcode;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rs;
  logic [DW-1:0]        opa;
  logic [DW-1:0]        opb;
  logic [DW-1:0]        alu_res;
  logic                 alu_c;
  logic                 alu_cupd;
  logic                 alu_writes;

  assign opcode = ir_opcode(ir);
  assign rd     = ir_rd(ir);
  assign rs     = ir_rs(ir);

  // Operand selection from the register file: A = R[rd], B = R[rs]
  always_comb begin
    opa = R0;
    opb = R0;
    case (rd)
      2'd0:    opa = R0;
      2'd1:    opa = R1;
      2'd2:    opa = R2;
      default: opa = R3;
    endcase
    case (rs)
      2'd0:    opb = R0;
      2'd1:    opb = R1;
      2'd2:    opb = R2;
      default: opb = R3;
    endcase
  end

  cmd_alu #(
    .DW (DW)
  ) u_alu (
    .opcode    (opcode),
    .a         (opa),
    .b         (opb),
    .result    (alu_res),
    .carry     (alu_c),
    .carry_upd (alu_cupd),
    .writes    (alu_writes)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; IR still holds the instruction during WB
  always_comb begin
    state_nxt       = state;
    imem.instr_rd   = 1'b0;
    imem.instr_addr = '0;
    enact           = 1'b0;
    pc_inc          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem.instr_rd   = 1'b1;
        imem.instr_addr = PC;
        state_nxt       = ST_DECODE;
      end
      ST_DECODE: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = (opcode == OP_HALT) ? ST_HALTED : ST_WB;
      end
      ST_WB: begin
        enact  = alu_writes;
        pc_inc = 1'b1;
`ifdef CMD_EXEC_AUTORUN_EN
        // PC stage advances on this edge, so the next FETCH sees the new PC
        state_nxt = ST_FETCH;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state != ST_IDLE) && (state != ST_HALTED);
  assign halted = (state == ST_HALTED);

  // Instruction register, result registers and flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir       <= '0;
      res_alu  <= '0;
      res_dest <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (state == ST_DECODE) begin
        ir <= imem.instr_data;
      end
      if ((state == ST_EXEC) && alu_writes) begin
        res_alu  <= alu_res;
        res_dest <= rd;
        flag_z   <= (alu_res == '0);
        if (alu_cupd) begin
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_exec_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_cmd_exec_seq
// Desc     : Self-checking bench for cmd_exec_seq. Models the instruction ROM,
//            the PC stage and the register file, and predicts each instruction
//            outcome with an arithmetic reference model. Build with
//            CMD_EXEC_AUTORUN_EN defined to exercise the free-running mode.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_cmd_exec_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] pc;
  logic [7:0] rf [4];
  logic [7:0] rom [256];
  logic [7:0] res_alu;
  logic [1:0] res_dest;
  logic       enact;
  logic       pc_inc;
  logic       busy;
  logic       halted;
  logic       flag_c;
  logic       flag_z;

  int n_checks = 0;
  int n_errors = 0;
  int n_enact  = 0;
  int n_pcinc  = 0;
  bit exp_c    = 1'b0;
  bit exp_z    = 1'b0;

  cmd_exec_seq_if imem ();

  cmd_exec_seq dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .PC       (pc),
    .R0       (rf[0]),
    .R1       (rf[1]),
    .R2       (rf[2]),
    .R3       (rf[3]),
    .imem     (imem),
    .res_alu  (res_alu),
    .res_dest (res_dest),
    .enact    (enact),
    .pc_inc   (pc_inc),
    .busy     (busy),
    .halted   (halted),
    .flag_c   (flag_c),
    .flag_z   (flag_z)
  );

  always #5 clk = ~clk;

  // Environment: ROM with one-cycle read latency, PC stage and register file
  always @(posedge clk) begin
    if (imem.instr_rd) imem.instr_data <= rom[imem.instr_addr];
    if (pc_inc) pc = pc + 8'd1;
    if (enact) rf[res_dest] = res_alu;
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (enact)  n_enact++;
    if (pc_inc) n_pcinc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic
  task automatic ref_exec(input logic [7:0] ir, input logic [7:0] a8, input logic [7:0] b8,
                          output bit w, output bit cu, output bit c, output logic [7:0] r);
    int a, b, s;
    a = int'(a8);
    b = int'(b8);
    s = 0; w = 1'b1; cu = 1'b0; c = 1'b0;
    case (ir[7:4])
      4'h1: begin s = a + b; cu = 1'b1; c = (s > 255);    end
      4'h2: begin s = a - b; cu = 1'b1; c = (a < b);      end
      4'h3: s = a & b;
      4'h4: s = a | b;
      4'h5: s = a ^ b;
      4'h6: s = 255 - a;
      4'h7: s = b;
      4'h8: begin s = a + 1; cu = 1'b1; c = (a == 255);   end
      4'h9: begin s = a - 1; cu = 1'b1; c = (a == 0);     end
      4'hA: begin s = a * 2; cu = 1'b1; c = (a >= 128);   end
      4'hB: begin s = a / 2; cu = 1'b1; c = (a % 2 == 1); end
      default: w = 1'b0;
    endcase
    r = 8'(s);
  endtask

  // One single-step instruction; spur selects a cycle (2..4) with a stray start
  task automatic run_one(input logic [7:0] ir, input int spur);
    logic [7:0] a, b, r;
    bit w, cu, c;
    rom[pc] = ir;
    a = rf[ir[3:2]];
    b = rf[ir[1:0]];
    ref_exec(ir, a, b, w, cu, c, r);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("fetch_rd", 32'(imem.instr_rd), 1);
    check("fetch_addr", 32'(imem.instr_addr), 32'(pc));
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      start = (spur == k);
      if (k < 4) check("mid_quiet", 32'({enact, pc_inc, imem.instr_rd}), 0);
    end
    check("wb_enact", 32'(enact), 32'(w));
    check("wb_pcinc", 32'(pc_inc), 1);
    if (w) begin
      check("wb_res", 32'(res_alu), 32'(r));
      check("wb_dest", 32'(res_dest), 32'(ir[3:2]));
      exp_z = (r == 8'h00);
      if (cu) exp_c = c;
    end
    check("flag_c", 32'(flag_c), 32'(exp_c));
    check("flag_z", 32'(flag_z), 32'(exp_z));
    @(negedge clk) start = 1'b0;
    check("idle_after", 32'({busy, imem.instr_rd}), 0);
  endtask

  initial begin
    clr   = 1'b0;
    start = 1'b0;
    pc    = 8'h00;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({imem.instr_rd, enact, pc_inc, busy, halted, flag_c, flag_z}), 0);
    check("rst_res", 32'({res_alu, res_dest}), 0);
    check("rst_addr", 32'(imem.instr_addr), 0);
    clr = 1'b1;
    @(negedge clk);

`ifdef CMD_EXEC_AUTORUN_EN
    begin
      bit dropped;
      rom[0] = 8'h81;
      rom[1] = 8'h81;
      rom[2] = 8'hF0;
      rf[0]  = 8'h00;
      dropped = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 60 && !halted; i++) begin
        if (!busy) dropped = 1'b1;
        @(negedge clk);
      end
      check("auto_halted", 32'(halted), 1);
      check("auto_r0", 32'(rf[0]), 2);
      check("auto_pcinc", 32'(n_pcinc), 2);
      check("auto_enact", 32'(n_enact), 2);
      check("auto_pc", 32'(pc), 2);
      check("auto_busy_held", 32'(dropped), 0);
      check("auto_busy_end", 32'(busy), 0);
    end
`else
    begin
      int e0, p0;
      // ADD R1,R2 with carry out
      rf[1] = 8'hF0;
      rf[2] = 8'h20;
      run_one(8'h16, 0);
      check("add_r1", 32'(rf[1]), 32'h10);

      // DEC R3 down to zero, then borrow past zero
      rf[3] = 8'h05;
      repeat (5) run_one(8'h9C, int'($urandom_range(0, 4)));
      check("dec_zero_res", 32'(res_alu), 0);
      check("dec_zero_z", 32'(flag_z), 1);
      run_one(8'h9C, 0);
      check("dec_wrap_res", 32'(res_alu), 32'hFF);
      check("dec_wrap_c", 32'(flag_c), 1);

      // NOP and undefined opcode: no write-back, stray starts while busy
      e0 = n_enact;
      p0 = n_pcinc;
      run_one(8'h00, 3);
      run_one(8'hD5, 4);
      check("nop_enact", 32'(n_enact - e0), 0);
      check("nop_pcinc", 32'(n_pcinc - p0), 2);

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int j = 0; j < 4; j++) rf[j] = 8'($urandom);
        end
        run_one({4'($urandom_range(0, 14)), 4'($urandom)}, int'($urandom_range(0, 4)));
      end

      // Reset while in EXEC: nothing issued afterwards
      rom[pc] = 8'h16;
      rf[1]   = 8'h33;
      rf[2]   = 8'h44;
      e0 = n_enact;
      p0 = n_pcinc;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) clr = 1'b0;
      #1;
      check("rst_exec_outs", 32'({imem.instr_rd, enact, pc_inc, busy, halted, flag_c, flag_z}), 0);
      check("rst_exec_res", 32'({res_alu, res_dest}), 0);
      @(negedge clk) clr = 1'b1;
      exp_c = 1'b0;
      exp_z = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_exec_enact", 32'(n_enact - e0), 0);
      check("rst_exec_pcinc", 32'(n_pcinc - p0), 0);
      check("rst_exec_busy", 32'(busy), 0);

      // HALT: no pc_inc, and later starts never fetch
      rom[pc] = 8'hF0;
      p0 = n_pcinc;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("halt_fetch", 32'(imem.instr_rd), 1);
      repeat (3) @(negedge clk);
      check("halt_state", 32'({halted, busy}), 32'h2);
      check("halt_pcinc", 32'(n_pcinc - p0), 0);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("halt_no_rd", 32'({imem.instr_rd, halted}), 1);
        @(negedge clk);
        check("halt_no_rd2", 32'({imem.instr_rd, halted}), 1);
      end
      check("halt_pcinc_end", 32'(n_pcinc - p0), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
